// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - LED PWM duty threshold controller: manual key stepping with auto-repeat, optional breathe ramp
// Breathe mode is built only when PWM_DUTY_CTRL_BREATHE_EN is defined.
module pwm_duty_ctrl #(
    parameter int DUTY_W       = 10,
    parameter int TICK_DIV     = 32768,
    parameter int REPEAT_TICKS = 8,
    parameter int STEP         = 1,
    parameter int DUTY_INIT    = 1016
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_up,
    input  logic              key_dn,
    input  logic              mode_sel,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic              at_max,
    output logic              at_min
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
    localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(DUTY_INIT);
    localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W+1)'(STEP);

`ifdef PWM_DUTY_CTRL_BREATHE_EN
    typedef enum logic [1:0] {MANUAL = 2'd0, BR_UP = 2'd1, BR_DN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {MANUAL = 2'd0} state_t;
    logic unused_mode_sel;
    assign unused_mode_sel = mode_sel;
`endif

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                rep_arm, rep_arm_nxt;
    logic                key_up_q, key_dn_q;
    logic                tick, up_edge, dn_edge, one_key;
    logic [DUTY_W:0]     up_sum, dn_diff;
    logic [DUTY_W-1:0]   duty_inc, duty_dec, duty_nxt;

    assign tick    = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign one_key = key_up ^ key_dn;
    assign up_edge = key_up & ~key_up_q & ~key_dn;
    assign dn_edge = key_dn & ~key_dn_q & ~key_up;

    // Widened by one bit so the carry/borrow tells us when to clamp.
    assign up_sum   = {1'b0, duty} + STEP_X;
    assign dn_diff  = {1'b0, duty} - STEP_X;
    assign duty_inc = (up_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : up_sum[DUTY_W-1:0];
    assign duty_dec = dn_diff[DUTY_W] ? '0 : dn_diff[DUTY_W-1:0];

    always_comb begin
        duty_nxt    = duty;
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        rep_arm_nxt = rep_arm;
        if (state == MANUAL) begin
            if (up_edge || dn_edge) begin
                duty_nxt    = up_edge ? duty_inc : duty_dec;
                hold_nxt    = '0;
                rep_arm_nxt = 1'b1;
            end else if (!one_key) begin
                hold_nxt    = '0;
                rep_arm_nxt = 1'b0;
            end else if (tick && rep_arm) begin
                // Only a hold that began with an accepted edge may auto-repeat.
                if (hold_cnt == HOLD_W'(REPEAT_TICKS))
                    duty_nxt = key_up ? duty_inc : duty_dec;
                else
                    hold_nxt = hold_cnt + 1'b1;
            end
`ifdef PWM_DUTY_CTRL_BREATHE_EN
            if (mode_sel)
                state_nxt = BR_UP;
        end else begin
            hold_nxt    = '0;
            rep_arm_nxt = 1'b0;
            if (tick) begin
                if (state == BR_UP) begin
                    duty_nxt = duty_inc;
                    if (duty_inc == DUTY_MAX)
                        state_nxt = BR_DN;
                end else begin
                    duty_nxt = duty_dec;
                    if (duty_dec == '0)
                        state_nxt = BR_UP;
                end
            end
            if (!mode_sel)
                state_nxt = MANUAL;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= MANUAL;
            tick_cnt <= '0;
            hold_cnt <= '0;
            rep_arm  <= 1'b0;
            key_up_q <= 1'b0;
            key_dn_q <= 1'b0;
            duty     <= DUTY_RST;
            duty_upd <= 1'b0;
            at_max   <= (DUTY_RST == DUTY_MAX);
            at_min   <= (DUTY_RST == '0);
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            hold_cnt <= hold_nxt;
            rep_arm  <= rep_arm_nxt;
            key_up_q <= key_up;
            key_dn_q <= key_dn;
            duty     <= duty_nxt;
            duty_upd <= (duty_nxt != duty);
            at_max   <= (duty_nxt == DUTY_MAX);
            at_min   <= (duty_nxt == '0);
        end
    end

endmodule
